// File: rtl/fsm_pkg.sv
// Shared state encoding and index-advance rule for the constant-output fsm and its monitor.
// Both sides call next_idx so their wrap behaviour stays identical.
package fsm_pkg;

  localparam int unsigned DefW = 3;
  localparam int unsigned DefN = 7;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } fsm_state_e;

  // Advance only when the state's advance input is high; wrap N-1 -> 0.
  function automatic int unsigned next_idx(input int unsigned idx, input logic adv_bit,
                                           input int unsigned n);
    if (!adv_bit) return idx;
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fsm_mon_cmp.sv
// Selects the expected constant c_sel from the packed constant vector and compares it with y.
module fsm_mon_cmp
  import fsm_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned N  = DefN,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0] cvec,
  input  logic [IW-1:0]  sel,
  input  logic [W-1:0]   y,
  output logic           match
);

  logic [W-1:0] c_sel;

  always_comb begin
    c_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == IW'(k)) c_sel = cvec[k*W +: W];
    end
  end

  assign match = (y == c_sel);

endmodule

// File: rtl/fsm_seq_monitor.sv
// Observer for the N-state constant-output fsm: locks on c_0, tracks the expected index, counts
// mismatches. Define FSM_MON_RESYNC_EN to return to HUNT on a mismatch instead of sticky ERR.
module fsm_seq_monitor
  import fsm_pkg::*;
#(
  parameter  int unsigned W     = DefW,
  parameter  int unsigned N     = DefN,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     adv,
  input  logic [N*W-1:0]   cvec,
  input  logic [W-1:0]     y,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [IW-1:0]    exp_idx
);

  fsm_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [IW-1:0]    sel;
  logic             match;

  // While hunting, the only candidate is c_0.
  assign sel = (state_q == TRACK) ? idx_q : '0;

  fsm_mon_cmp #(
    .W  (W),
    .N  (N),
    .IW (IW)
  ) u_cmp (
    .cvec  (cvec),
    .sel   (sel),
    .y     (y),
    .match (match)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (en && match) begin
          state_d = TRACK;
          idx_d   = IW'(next_idx(0, adv[0], N));
        end
      end
      TRACK: begin
        if (en) begin
          if (match) begin
            idx_d = IW'(next_idx(32'(idx_q), adv[idx_q], N));
          end else begin
            err_d = 1'b1;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef FSM_MON_RESYNC_EN
            state_d = HUNT;
            idx_d   = '0;
`else
            state_d = ERR;
`endif
          end
        end
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = HUNT;
        idx_d   = '0;
      end
    endcase
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;
  assign exp_idx = idx_q;

endmodule
